// File: rtl/fft_pkg.sv
// Shared types and constants for the MDC FFT stages: data widths,
// the complex sample type and the W8 twiddle table.
package fft_pkg;

  localparam int DATA_W  = 9;
  localparam int BF_W    = 10;
  localparam int MUL_W   = 19;
  localparam int TW_FRAC = 7;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  // W8^k in Q.7: (128,0), (91,-91), (0,-128), (-91,-91)
  function automatic cplx_t w8(input logic [1:0] k);
    cplx_t w;
    case (k)
      2'd0:    w = '{re: 9'h080, im: 9'h000};
      2'd1:    w = '{re: 9'h05B, im: 9'h1A5};
      2'd2:    w = '{re: 9'h000, im: 9'h180};
      default: w = '{re: 9'h1A5, im: 9'h1A5};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Enable-gated shift register of packed complex samples. A synchronous clear
// empties the line; if it coincides with an enable the new sample still enters.
module fft_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [2*WIDTH-1:0] din_i,
  output logic [2*WIDTH-1:0] dout_o
);

  logic [2*WIDTH-1:0] taps_q [DEPTH];
  logic [2*WIDTH-1:0] taps_d [DEPTH];

  always_comb begin
    taps_d[0] = taps_q[0];
    if (en_i)       taps_d[0] = din_i;
    else if (clr_i) taps_d[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      taps_d[i] = taps_q[i];
      if (clr_i)     taps_d[i] = '0;
      else if (en_i) taps_d[i] = taps_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) taps_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) taps_q[i] <= taps_d[i];
    end
  end

  assign dout_o = taps_q[DEPTH-1];

endmodule

// File: rtl/fft_state3.sv
// Third radix-2 DIF stage of the 32-point MDC FFT: D=4 commutator, butterfly
// and W8 twiddle multiply with registered outputs. WIDTH must equal DATA_W.
module fft_state3
  import fft_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             sof,
  input  logic [WIDTH-1:0] state2_outUp_re,
  input  logic [WIDTH-1:0] state2_outUp_im,
  input  logic [WIDTH-1:0] state2_outL_re,
  input  logic [WIDTH-1:0] state2_outL_im,
  output logic             out_valid,
  output logic [WIDTH-1:0] state3_outUp_re,
  output logic [WIDTH-1:0] state3_outUp_im,
  output logic [WIDTH-1:0] state3_outL_re,
  output logic [WIDTH-1:0] state3_outL_im
);

  logic [2:0] cnt_q, cnt_d, idx;
  logic       primed_q, primed_d;
  logic       outValid_q, outValid_d;
  logic       resync;
  cplx_t      outUp_q, outUp_d, outL_q, outL_d;
  cplx_t      upIn, loIn, ldTap, aTap, ld, a, comUp, comL, tw;
  logic signed [BF_W-1:0]  upRe, upIm, dnRe, dnIm;
  logic signed [MUL_W-1:0] mulRe, mulIm;
  logic       unusedBits;

  assign upIn   = {state2_outUp_re, state2_outUp_im};
  assign loIn   = {state2_outL_re, state2_outL_im};
  assign idx    = (in_valid && sof) ? 3'd0 : cnt_q;
  assign resync = in_valid && sof && (cnt_q != 3'd0);

  fft_delay_line #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_ld_line (
    .clk(clk), .rst_n(rst_n), .en_i(in_valid), .clr_i(resync),
    .din_i(loIn), .dout_o(ldTap)
  );

  fft_delay_line #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_a_line (
    .clk(clk), .rst_n(rst_n), .en_i(in_valid), .clr_i(resync),
    .din_i(comUp), .dout_o(aTap)
  );

  // A resyncing pair sees the lines as already emptied.
  assign ld    = resync ? '0 : ldTap;
  assign a     = resync ? '0 : aTap;
  assign comUp = idx[2] ? ld : upIn;
  assign comL  = idx[2] ? upIn : ld;
  assign tw    = w8(idx[1:0]);

  always_comb begin
    upRe  = BF_W'($signed(a.re)) + BF_W'($signed(comL.re));
    upIm  = BF_W'($signed(a.im)) + BF_W'($signed(comL.im));
    dnRe  = BF_W'($signed(a.re)) - BF_W'($signed(comL.re));
    dnIm  = BF_W'($signed(a.im)) - BF_W'($signed(comL.im));
    mulRe = MUL_W'(dnRe) * MUL_W'($signed(tw.re)) - MUL_W'(dnIm) * MUL_W'($signed(tw.im));
    mulIm = MUL_W'(dnRe) * MUL_W'($signed(tw.im)) + MUL_W'(dnIm) * MUL_W'($signed(tw.re));
  end

  assign unusedBits = ^{upRe[BF_W-1], upIm[BF_W-1],
                        mulRe[MUL_W-1:DATA_W+TW_FRAC], mulRe[TW_FRAC-1:0],
                        mulIm[MUL_W-1:DATA_W+TW_FRAC], mulIm[TW_FRAC-1:0]};

  always_comb begin
    cnt_d      = cnt_q;
    primed_d   = primed_q;
    outValid_d = in_valid && primed_q && !resync;
    outUp_d    = outUp_q;
    outL_d     = outL_q;
    if (in_valid) begin
      cnt_d   = idx + 3'd1;
      outUp_d = {upRe[DATA_W-1:0], upIm[DATA_W-1:0]};
      outL_d  = {mulRe[DATA_W+TW_FRAC-1:TW_FRAC], mulIm[DATA_W+TW_FRAC-1:TW_FRAC]};
      if (resync)          primed_d = 1'b0;
      if (idx == 3'd7)     primed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      primed_q   <= 1'b0;
      outValid_q <= 1'b0;
      outUp_q    <= '0;
      outL_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      primed_q   <= primed_d;
      outValid_q <= outValid_d;
      outUp_q    <= outUp_d;
      outL_q     <= outL_d;
    end
  end

  assign out_valid       = outValid_q;
  assign state3_outUp_re = outUp_q.re;
  assign state3_outUp_im = outUp_q.im;
  assign state3_outL_re  = outL_q.re;
  assign state3_outL_im  = outL_q.im;

endmodule
